// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Holds the controller state type, the BCD digit type, digit constants
// and the helper that sizes the shift counter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX_DIGIT = 4'd9;
  localparam digit_t BCD_CORR      = 4'd3;

  // Counter width that can hold 0 .. bin_w-1 (at least one bit).
  function automatic int cnt_width(input int bin_w);
    return (bin_w > 2) ? $clog2(bin_w) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Single-digit corrector for reverse double dabble.
// Ports:
//   d       in   4  BCD digit
//   q       out  4  d-3 when d>=8, otherwise d (no borrow to neighbours)
//   invalid out  1  d is not a decimal digit (d>9)
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  digit_t d,
  output digit_t q,
  output logic   invalid
);

  assign q       = (d >= 4'd8) ? d - BCD_CORR : d;
  assign invalid = (d > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_binary_seq.sv
// Sequential 8421-BCD to binary converter (reverse double dabble).
// One conversion in flight; valid/ready handshakes on both sides.
// Ports:
//   clk       in   1          system clock, rising edge
//   rst_n     in   1          asynchronous active-low reset
//   in_valid  in   1          bcd_in valid
//   in_ready  out  1          converter idle, can accept bcd_in
//   bcd_in    in   4*DIGITS   BCD digits, most significant in top nibble
//   out_valid out  1          result valid, held until out_ready
//   out_ready in   1          consumer accepts result
//   bin_out   out  BIN_W      binary result
//   err_out   out  1          a digit was >9 (qualified by out_valid)
module bcd_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state, state_next;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [CNT_W-1:0]   count;
  logic               err_reg;

  logic [BCD_W-1:0]   bcd_sh;
  logic [BIN_W-1:0]   bin_sh;
  logic [BCD_W-1:0]   corr_in;
  logic [BCD_W-1:0]   corr_out;
  logic [DIGITS-1:0]  digit_bad;
  logic               any_bad;

  // One right shift of the {bcd, bin} pair; the BCD LSB falls into the
  // binary MSB.
  assign bcd_sh = bcd_reg >> 1;
  assign bin_sh = {bcd_reg[0], bin_reg[BIN_W-1:1]};

  // The digit correctors are shared: in IDLE they screen the incoming
  // word for non-decimal digits, in SHIFT they correct the shifted field.
  assign corr_in = (state == IDLE) ? bcd_in : bcd_sh;
  assign any_bad = |digit_bad;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_corr u_corr (
      .d       (corr_in[4*i +: 4]),
      .q       (corr_out[4*i +: 4]),
      .invalid (digit_bad[i])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = any_bad ? DONE : SHIFT;
      end
      SHIFT: begin
        if (count == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Working registers. An invalid word leaves bin_reg cleared, so the
  // flagged result reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      count   <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            count   <= '0;
            err_reg <= any_bad;
          end
        end
        SHIFT: begin
          bcd_reg <= corr_out;
          bin_reg <= bin_sh;
          count   <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bin_out = bin_reg;
  assign err_out = err_reg;

endmodule
